spi_get_id: RTL and testbench

- Single-shot SPI master that reads the first JEDEC ID byte (manufacturer ID) from an external SPI flash after reset.
- Sends command 0x9F in SPI mode 0, MSB first, then clocks in one byte and presents it on recv_msg.
- Sits between the FPGA fabric (12 MHz system clock) and the flash pins. Used for bring-up and debug, with state and SCK-phase debug outputs.

---
 rtl/spi_get_id_pkg.sv | 16 +
 rtl/spi_get_id_sck_gen.sv | 45 ++++
 rtl/spi_get_id.sv | 120 ++++++++++++
 tb/tb_spi_get_id.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_get_id_pkg.sv
// Shared constants for the JEDEC-ID reader: state encoding, command byte, byte width.
package spi_get_id_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] JEDEC_CMD = 8'h9F;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CS_SETUP = 4'd1,
        SEND     = 4'd2,
        RECV     = 4'd3,
        CS_HOLD  = 4'd4,
        DONE     = 4'd5
    } state_t;

endpackage

// File: rtl/spi_get_id_sck_gen.sv
// SCK half-period divider: registered SCK, the current half, and a strobe on the last clock of each half.
module spi_sck_gen #(
    parameter int HALF_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic toggle_en,
    output logic sck,
    output logic sck_half,
    output logic half_done
);

    localparam int CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_DIV - 1);

    // NOTE: declaration initialisers give the power-up state, so the block runs even if rst never asserts.
    logic [CNT_W-1:0] div_cnt = '0;
    logic             half_q  = 1'b0;

    assign half_done = count_en && (div_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            half_q  <= 1'b0;
        end else begin
            if (!count_en || half_done) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end
            // SCK only runs while bits are on the wire; it parks low otherwise.
            if (!toggle_en) begin
                half_q <= 1'b0;
            end else if (half_done) begin
                half_q <= ~half_q;
            end
        end
    end

    assign sck      = half_q;
    assign sck_half = half_q;

endmodule

// File: rtl/spi_get_id.sv
// Single-shot SPI mode-0 master: sends CMD, reads back one byte (flash manufacturer ID) and holds it.
module spi_get_id
    import spi_get_id_pkg::*;
#(
    parameter logic [BYTE_W-1:0] CMD      = JEDEC_CMD,
    parameter int                HALF_DIV = 1
) (
    input  logic              clk12MHz,
    input  logic              rst,
    input  logic              sdi,
    output logic              sdo,
    output logic              cs,
    output logic              sck,
    output logic [BYTE_W-1:0] recv_msg,
    output logic [3:0]        debug_states,
    output logic              debug_sck_halfs
);

    localparam int BIT_W = $clog2(BYTE_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BYTE_W - 1);

    state_t            state    = IDLE;
    logic [BYTE_W-1:0] tx_shift = '0;
    logic [BYTE_W-2:0] rx_shift = '0;
    logic [BIT_W-1:0]  bit_cnt  = '0;
    logic              cs_q     = 1'b1;
    logic [BYTE_W-1:0] recv_q   = '0;

    logic count_en;
    logic toggle_en;
    logic half_done;
    logic sck_half;
    logic high_done;

    assign toggle_en = (state == SEND) || (state == RECV);
    assign count_en  = toggle_en || (state == CS_SETUP) || (state == CS_HOLD);
    assign high_done = half_done && sck_half;

    spi_sck_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_sck_gen (
        .clk       (clk12MHz),
        .rst       (rst),
        .count_en  (count_en),
        .toggle_en (toggle_en),
        .sck       (sck),
        .sck_half  (sck_half),
        .half_done (half_done)
    );

    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            state    <= IDLE;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            cs_q     <= 1'b1;
            recv_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_shift <= CMD;
                    bit_cnt  <= '0;
                    cs_q     <= 1'b0;
                    state    <= CS_SETUP;
                end
                CS_SETUP: begin
                    if (half_done) state <= SEND;
                end
                SEND: begin
                    // sdo is the shift MSB, so it only moves at the start of a low half.
                    if (high_done) begin
                        if (bit_cnt == LAST_BIT) begin
                            tx_shift <= '0;
                            bit_cnt  <= '0;
                            state    <= RECV;
                        end else begin
                            tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                RECV: begin
                    if (high_done) begin
                        rx_shift <= {rx_shift[BYTE_W-3:0], sdi};
                        if (bit_cnt == LAST_BIT) begin
                            recv_q  <= {rx_shift, sdi};
                            bit_cnt <= '0;
                            state   <= CS_HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                CS_HOLD: begin
                    if (half_done) begin
                        cs_q  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    tx_shift <= '0;
                    bit_cnt  <= '0;
                    cs_q     <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign sdo             = tx_shift[BYTE_W-1];
    assign cs              = cs_q;
    assign recv_msg        = recv_q;
    assign debug_states    = state;
    assign debug_sck_halfs = sck_half;

endmodule

// File: tb/tb_spi_get_id.sv
// Bench for spi_get_id: flash model plus transaction-level expectations for HALF_DIV = 1 and 3.
module tb_spi_get_id;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b0, sdi0 = 1'b0, sdo0, cs0, sck0, hf0;
    logic [7:0] recv0;
    logic [3:0] st0;
    logic       rst3 = 1'b0, sdi3 = 1'b0, sdo3, cs3, sck3, hf3;
    logic [7:0] recv3;
    logic [3:0] st3;

    spi_get_id #(.HALF_DIV(1)) dut (
        .clk12MHz        (clk),
        .rst             (rst0),
        .sdi             (sdi0),
        .sdo             (sdo0),
        .cs              (cs0),
        .sck             (sck0),
        .recv_msg        (recv0),
        .debug_states    (st0),
        .debug_sck_halfs (hf0)
    );

    spi_get_id #(.HALF_DIV(3)) dut3 (
        .clk12MHz        (clk),
        .rst             (rst3),
        .sdi             (sdi3),
        .sdo             (sdo3),
        .cs              (cs3),
        .sck             (sck3),
        .recv_msg        (recv3),
        .debug_states    (st3),
        .debug_sck_halfs (hf3)
    );

    int    vectors     = 0;
    int    miscompares = 0;
    string cur_test    = "";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s/%s: got %0h expected %0h", cur_test, tag, got, exp);
        end
    endtask

    task automatic set_rst(input int which, input logic v);
        if (which == 0) rst0 = v; else rst3 = v;
    endtask

    task automatic set_sdi(input int which, input logic v);
        if (which == 0) sdi0 = v; else sdi3 = v;
    endtask

    task automatic sample(input int which, output logic c, output logic s, output logic d,
                          output logic h, output logic [7:0] r, output logic [3:0] st);
        if (which == 0) begin
            c = cs0; s = sck0; d = sdo0; h = hf0; r = recv0; st = st0;
        end else begin
            c = cs3; s = sck3; d = sdo3; h = hf3; r = recv3; st = st3;
        end
    endtask

    // Phase the transaction is in after `cyc` clocks out of reset.
    function automatic int exp_state(input int cyc, input int hd);
        if (cyc < 1)          return 0;
        if (cyc < 1 + hd)     return 1;
        if (cyc < 1 + 17*hd)  return 2;
        if (cyc < 1 + 33*hd)  return 3;
        if (cyc < 1 + 34*hd)  return 4;
        return 5;
    endfunction

    // One full transaction; the flash returns flash_byte MSB first, changing sdi after each SCK fall.
    task automatic run_txn(input int which, input int hd, input logic [7:0] flash_byte,
                           input logic idle, input int rst_cycles);
        int done_cyc = 1 + 34*hd;
        int recv_cyc = 1 + 33*hd;
        int fall_cyc = -1, rise_cyc = -1, last_rise = -1;
        int rises = 0, falls = 0, stray = 0, interval_bad = 0, rx_sdo_bad = 0;
        int changes = 0, seq_bad = 0, half_bad = 0, recv_bad = 0;
        logic [7:0] tx_bits = '0;
        logic prev_sck = 1'b0;
        logic [3:0] prev_st = 4'd0;
        logic c, s, d, h;
        logic [7:0] r;
        logic [3:0] st;
        logic [7:0] exp_recv;

        set_sdi(which, idle);
        if (rst_cycles > 0) begin
            set_rst(which, 1'b1);
            repeat (rst_cycles) @(posedge clk);
            #1;
            set_rst(which, 1'b0);
        end
        for (int cyc = 1; cyc <= done_cyc + 4; cyc++) begin
            @(posedge clk);
            #1;
            sample(which, c, s, d, h, r, st);
            if (!c && fall_cyc < 0) fall_cyc = cyc;
            if (c && fall_cyc >= 0 && rise_cyc < 0) rise_cyc = cyc;
            if (s && !prev_sck) begin
                if (c) stray++;
                rises++;
                if (rises <= 8) tx_bits = {tx_bits[6:0], d};
                else if (d) rx_sdo_bad++;
                if (last_rise >= 0 && cyc - last_rise != 2*hd) interval_bad++;
                last_rise = cyc;
            end
            if (!s && prev_sck) falls++;
            if (falls >= 8 && falls < 16) set_sdi(which, flash_byte[15 - falls]);
            else set_sdi(which, idle);
            if (st != prev_st) begin
                changes++;
                if (st != prev_st + 4'd1) seq_bad++;
                prev_st = st;
            end
            if (h !== (((st == 4'd2) || (st == 4'd3)) ? s : 1'b0)) half_bad++;
            exp_recv = (cyc >= recv_cyc) ? flash_byte : 8'h00;
            if (r !== exp_recv) recv_bad++;
            prev_sck = s;
        end
        check("cs_fall_clk",    fall_cyc,     1);
        check("cs_rise_clk",    rise_cyc,     done_cyc);
        check("sck_rises",      rises,        16);
        check("sck_outside_cs", stray,        0);
        check("sck_period",     interval_bad, 0);
        check("sdo_cmd",        tx_bits,      8'h9F);
        check("sdo_low_recv",   rx_sdo_bad,   0);
        check("state_changes",  changes,      5);
        check("state_order",    seq_bad,      0);
        check("sck_halfs",      half_bad,     0);
        check("recv_timing",    recv_bad,     0);
        check("recv_msg",       r,            flash_byte);
        check("final_state",    st,           5);
        check("final_cs",       c,            1);
    endtask

    // Start a transaction, hit reset after at_cyc clocks, and check every output returns to idle.
    task automatic abort_txn(input int which, input int hd, input int at_cyc);
        logic c, s, d, h;
        logic [7:0] r;
        logic [3:0] st;
        set_sdi(which, 1'b1);
        set_rst(which, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        set_rst(which, 1'b0);
        repeat (at_cyc) @(posedge clk);
        #1;
        sample(which, c, s, d, h, r, st);
        check("abort_pre_state", st, exp_state(at_cyc, hd));
        set_rst(which, 1'b1);
        @(posedge clk);
        #1;
        sample(which, c, s, d, h, r, st);
        check("abort_cs",    c,  1);
        check("abort_sck",   s,  0);
        check("abort_sdo",   d,  0);
        check("abort_recv",  r,  8'h00);
        check("abort_state", st, 0);
        check("abort_halfs", h,  0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int which, hd, rc;
        logic [7:0] b;
        logic idle;

        cur_test = "no_reset_sdi0";
        run_txn(0, 1, 8'h00, 1'b0, 0);

        cur_test = "reset_then_EF";
        run_txn(0, 1, 8'hEF, 1'b0, 4);

        cur_test = "sdi1_FF";
        run_txn(0, 1, 8'hFF, 1'b1, 2);

        cur_test = "abort_send_bit3";
        abort_txn(0, 1, 10);
        run_txn(0, 1, 8'hEF, 1'b0, 1);

        cur_test = "abort_done";
        abort_txn(0, 1, 36);
        run_txn(0, 1, 8'hEF, 1'b0, 1);

        cur_test = "div3_C2";
        run_txn(1, 3, 8'hC2, 1'b0, 3);

        for (int i = 0; i < 8; i++) begin
            which = int'($urandom_range(0, 1));
            hd    = (which == 0) ? 1 : 3;
            b     = 8'($urandom);
            idle  = 1'($urandom);
            rc    = int'($urandom_range(1, 4));
            cur_test = $sformatf("rand%0d_h%0d_%02h", i, hd, b);
            if ($urandom_range(0, 1) == 1) begin
                abort_txn(which, hd, int'($urandom_range(1, 34*hd + 3)));
                rc = 1;
            end
            run_txn(which, hd, b, idle, rc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
